// File: rtl/burst_memory.sv
// Burst-mode line memory: accepts one read/write line request, waits DELAY cycles,
// then streams or absorbs four 64-bit beats of a 256-bit line with resp_o held high.
module burst_memory #(
  parameter int LINE_BITS = 8,
  parameter int DELAY     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] address_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  localparam int         WORDS    = 4 << LINE_BITS;
  localparam logic [3:0] DELAY_M1 = 4'((DELAY > 0) ? DELAY - 1 : 0);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [1:0]             beat_q, beat_d;
  logic [1:0]             beat_nx;
  logic                   op_write_q, op_write_d;
  logic [LINE_BITS-1:0]   idx_q, idx_d;
  logic [LINE_BITS-1:0]   req_idx;
  logic                   resp_d;
  logic [63:0]            burst_d;
  logic                   op_req;
  logic                   mem_we;
  logic [63:0]            mem [0:WORDS-1];
  logic                   unused_addr;

  assign req_idx     = address_i[LINE_BITS+4:5];
  assign unused_addr = ^{address_i[31:LINE_BITS+5], address_i[4:0]};
  assign beat_nx     = beat_q + 2'd1;
  // The latched op's own request line keeps the transaction alive; the other is ignored.
  assign op_req      = op_write_q ? write_i : read_i;
  assign state_dbg   = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    op_write_d = op_write_q;
    idx_d      = idx_q;
    resp_d     = resp_o;
    burst_d    = burst_o;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_i ^ write_i) begin
          op_write_d = write_i;
          idx_d      = req_idx;
          if (DELAY == 0) begin
            state_d = BURST;
            beat_d  = 2'd0;
            resp_d  = 1'b1;
            if (!write_i) burst_d = mem[{req_idx, 2'd0}];
          end else begin
            state_d = WAIT;
            cnt_d   = DELAY_M1;
          end
        end
      end
      WAIT: begin
        if (!op_req) begin
          state_d = IDLE;
          resp_d  = 1'b0;
        end else if (cnt_q == 4'd0) begin
          state_d = BURST;
          beat_d  = 2'd0;
          resp_d  = 1'b1;
          if (!op_write_q) burst_d = mem[{idx_q, 2'd0}];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      BURST: begin
        if (!op_req) begin
          state_d = IDLE;
          resp_d  = 1'b0;
        end else begin
          mem_we = op_write_q;
          if (beat_q == 2'd3) begin
            state_d = DONE;
            beat_d  = 2'd0;
            resp_d  = 1'b0;
          end else begin
            beat_d = beat_nx;
            if (!op_write_q) burst_d = mem[{idx_q, beat_nx}];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        resp_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      beat_q     <= 2'd0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      resp_o     <= 1'b0;
      burst_o    <= 64'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      op_write_q <= op_write_d;
      idx_q      <= idx_d;
      resp_o     <= resp_d;
      burst_o    <= burst_d;
    end
  end

  // Storage has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) mem[{idx_q, beat_q}] <= burst_i;
  end

endmodule

// File: tb/tb_burst_memory.sv
// Directed bench for burst_memory: one DELAY=4 instance and one DELAY=0 instance.
module tb_burst_memory;

  logic        clk;
  logic        reset_n;
  logic        read_i, write_i;
  logic [31:0] address_i;
  logic [63:0] burst_i;
  logic [63:0] burst_o;
  logic        resp;
  logic [1:0]  state_dbg;

  logic        z_read, z_write;
  logic [31:0] z_address;
  logic [63:0] z_burst_i;
  logic [63:0] z_burst_o;
  logic        z_resp;
  logic [1:0]  z_state;

  int checks = 0;
  int errors = 0;

  logic [63:0] line_d [4];

  burst_memory #(.LINE_BITS(8), .DELAY(4)) dut (
    .clk(clk), .reset_n(reset_n), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .burst_i(burst_i), .burst_o(burst_o),
    .resp_o(resp), .state_dbg(state_dbg)
  );

  burst_memory #(.LINE_BITS(8), .DELAY(0)) dut_z (
    .clk(clk), .reset_n(reset_n), .read_i(z_read), .write_i(z_write),
    .address_i(z_address), .burst_i(z_burst_i), .burst_o(z_burst_o),
    .resp_o(z_resp), .state_dbg(z_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_resp(input bit z);
    return z ? z_resp : resp;
  endfunction

  function automatic logic [63:0] cur_burst(input bit z);
    return z ? z_burst_o : burst_o;
  endfunction

  task automatic set_req(input bit z, input logic rd, input logic wr, input logic [31:0] addr);
    if (z) begin
      z_read = rd; z_write = wr; z_address = addr;
    end else begin
      read_i = rd; write_i = wr; address_i = addr;
    end
  endtask

  task automatic set_data(input bit z, input logic [63:0] d);
    if (z) z_burst_i = d;
    else   burst_i   = d;
  endtask

  // One transaction; beats < 4 drops the request during beat 'beats' (abort).
  task automatic run_op(input bit z, input bit wr, input logic [31:0] addr, input int dly,
                        input int beats, input bit chk_data, input string tag);
    bit dropped;
    dropped = 1'b0;
    @(negedge clk);
    set_req(z, !wr, wr, addr);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk({tag, "_wait_resp"}, 64'(cur_resp(z)), 64'd0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("%s_beat%0d_resp", tag, k), 64'(cur_resp(z)), 64'd1);
      if (k == beats) begin
        set_req(z, 1'b0, 1'b0, addr);
        dropped = 1'b1;
        break;
      end
      if (wr) set_data(z, line_d[k]);
      else if (chk_data) chk($sformatf("%s_beat%0d_data", tag, k), cur_burst(z), line_d[k]);
    end
    @(negedge clk);
    chk({tag, "_end_resp"}, 64'(cur_resp(z)), 64'd0);
    if (!dropped) set_req(z, 1'b0, 1'b0, addr);
  endtask

  initial begin
    reset_n = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'd0); burst_i = 64'd0;
    set_req(1, 1'b0, 1'b0, 32'd0); z_burst_i = 64'd0;
    #1 reset_n = 1'b0;
    #3;
    chk("reset_resp", 64'(resp), 64'd0);
    chk("reset_burst", burst_o, 64'd0);
    chk("reset_state", 64'(state_dbg), 64'd0);
    chk("reset_z_resp", 64'(z_resp), 64'd0);
    chk("reset_z_burst", z_burst_o, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // write then read, DELAY=4
    line_d = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    run_op(0, 1, 32'h0000_0040, 4, 4, 1, "wr40");
    run_op(0, 0, 32'h0000_0040, 4, 4, 1, "rd40");

    // aliasing: 0x2040, 0x0040 and 0x005F all map to line 2
    line_d = '{64'hAAAA_0000_0000_0000, 64'hAAAA_1111_0000_0001,
               64'hAAAA_2222_0000_0002, 64'hAAAA_3333_0000_0003};
    run_op(0, 1, 32'h0000_2040, 4, 4, 1, "wr2040");
    run_op(0, 0, 32'h0000_0040, 4, 4, 1, "alias40");
    run_op(0, 0, 32'h0000_005F, 4, 4, 1, "alias5f");

    // abort: full line at 0x80, then a write dropped after beat 1
    line_d = '{64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
               64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
    run_op(0, 1, 32'h0000_0080, 4, 4, 1, "wr80");
    line_d = '{64'h9999_9999_9999_9999, 64'hBBBB_BBBB_BBBB_BBBB,
               64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    run_op(0, 1, 32'h0000_0080, 4, 2, 1, "abort");
    chk("abort_idle", 64'(state_dbg), 64'd0);
    line_d = '{64'h9999_9999_9999_9999, 64'hBBBB_BBBB_BBBB_BBBB,
               64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
    run_op(0, 0, 32'h0000_0080, 4, 4, 1, "rd_after_abort");

    // illegal: both requests high for 10 cycles
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 32'h0000_0080);
    burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("illegal_resp", 64'(resp), 64'd0);
    end
    set_req(0, 1'b0, 1'b0, 32'd0);
    run_op(0, 0, 32'h0000_0080, 4, 4, 1, "rd_after_illegal");

    // reset during beat 2 of a read of line 2
    line_d = '{64'hAAAA_0000_0000_0000, 64'hAAAA_1111_0000_0001,
               64'hAAAA_2222_0000_0002, 64'hAAAA_3333_0000_0003};
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'h0000_0040);
    repeat (4) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("pre_reset_resp", 64'(resp), 64'd1);
    chk("pre_reset_data", burst_o, line_d[2]);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_resp", 64'(resp), 64'd0);
    chk("async_reset_burst", burst_o, 64'd0);
    set_req(0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(0, 0, 32'h0000_0040, 4, 4, 1, "rd_after_reset");

    // DELAY=0: unwritten line, then write/read
    run_op(1, 0, 32'h0000_0600, 0, 4, 0, "z_unwritten");
    line_d = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               64'h0F0F_0F0F_F0F0_F0F0, 64'h1234_0000_0000_4321};
    run_op(1, 1, 32'h0000_0020, 0, 4, 1, "z_wr20");
    run_op(1, 0, 32'h0000_0020, 0, 4, 1, "z_rd20");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
